// File: rtl/elevator_car_controller_pkg.sv
// Shared types and constants for the elevator car controller slice.
package elevator_car_controller_pkg;

    localparam int unsigned FLOOR_W       = 4;
    localparam int unsigned SETTLE_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_MOVE   = 2'd2,
        ST_DOOR   = 2'd3
    } state_t;

endpackage

// File: rtl/elevator_car_controller_timer.sv
// Loadable down-counter with a zero flag; shared by travel and door timing.
module elevator_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over decrement; the count saturates at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/elevator_car_controller.sv
// Car motion sequencer: accepts one floor request, settles while the external
// comparator catches up, steps one floor per travel period, then opens the door.
module elevator_car_controller
    import elevator_car_controller_pkg::*;
#(
    parameter int unsigned NUM_FLOORS    = 10,
    parameter int unsigned TRAVEL_CYCLES = 50,
    parameter int unsigned DOOR_CYCLES   = 100,
    parameter int unsigned CNT_W         = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [FLOOR_W-1:0] req_floor,
    output logic               req_ready,
    output logic               req_err,
    input  logic               isUp,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic [FLOOR_W-1:0] tgt_floor,
    output logic               moving,
    output logic               door_open,
    output logic               arrived
);

    localparam logic [FLOOR_W-1:0] LP_TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W:0]   LP_NUM_FLOORS = (FLOOR_W + 1)'(NUM_FLOORS);
    localparam logic [CNT_W-1:0]   LP_TRAVEL_LD  = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LP_DOOR_LD    = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [1:0]         LP_SETTLE_END = 2'(SETTLE_CYCLES - 1);

    state_t             r_state;
    logic [FLOOR_W-1:0] r_cur_floor;
    logic [FLOOR_W-1:0] r_tgt_floor;
    logic               r_dir;
    logic [1:0]         r_settle_cnt;
    logic               r_moving;
    logic               r_door_open;
    logic               r_arrived;
    logic               r_req_err;

    state_t             w_state_nxt;
    logic [FLOOR_W-1:0] w_cur_nxt;
    logic [FLOOR_W-1:0] w_tgt_nxt;
    logic               w_dir_nxt;
    logic [1:0]         w_settle_nxt;
    logic               w_arrived_nxt;
    logic               w_err_nxt;
    logic [FLOOR_W-1:0] w_step;
    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_dec;
    logic               w_zero;

    elevator_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // State and registered outputs; reset overrides any in-flight trip.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cur_floor  <= '0;
            r_tgt_floor  <= '0;
            r_dir        <= 1'b0;
            r_settle_cnt <= '0;
            r_moving     <= 1'b0;
            r_door_open  <= 1'b0;
            r_arrived    <= 1'b0;
            r_req_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_floor  <= w_cur_nxt;
            r_tgt_floor  <= w_tgt_nxt;
            r_dir        <= w_dir_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_moving     <= (w_state_nxt == ST_MOVE);
            r_door_open  <= (w_state_nxt == ST_DOOR);
            r_arrived    <= w_arrived_nxt;
            r_req_err    <= w_err_nxt;
        end
    end

    // Next-state, datapath updates and timer control.
    always_comb begin
        w_state_nxt   = r_state;
        w_cur_nxt     = r_cur_floor;
        w_tgt_nxt     = r_tgt_floor;
        w_dir_nxt     = r_dir;
        w_settle_nxt  = r_settle_cnt;
        w_arrived_nxt = 1'b0;
        w_err_nxt     = 1'b0;
        w_step        = r_dir ? (r_cur_floor + FLOOR_W'(1)) : (r_cur_floor - FLOOR_W'(1));
        w_load        = 1'b0;
        w_load_val    = '0;
        w_dec         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if ({1'b0, req_floor} >= LP_NUM_FLOORS) begin
                        w_err_nxt = 1'b1;
                    end else if (req_floor == r_cur_floor) begin
                        w_tgt_nxt     = req_floor;
                        w_state_nxt   = ST_DOOR;
                        w_arrived_nxt = 1'b1;
                        w_load        = 1'b1;
                        w_load_val    = LP_DOOR_LD;
                    end else begin
                        w_tgt_nxt    = req_floor;
                        w_settle_nxt = '0;
                        w_load       = 1'b1;
                        w_load_val   = '0;
                        w_state_nxt  = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                // isUp is only trusted here, once the comparator has seen tgt_floor.
                if (r_settle_cnt == LP_SETTLE_END) begin
                    w_dir_nxt   = isUp;
                    w_load      = 1'b1;
                    w_load_val  = LP_TRAVEL_LD;
                    w_state_nxt = ST_MOVE;
                end else begin
                    w_settle_nxt = r_settle_cnt + 2'd1;
                end
            end
            ST_MOVE: begin
                if (w_zero) begin
                    if ((r_dir && (r_cur_floor == LP_TOP_FLOOR)) ||
                        (!r_dir && (r_cur_floor == '0))) begin
                        w_state_nxt   = ST_DOOR;
                        w_arrived_nxt = 1'b1;
                        w_load        = 1'b1;
                        w_load_val    = LP_DOOR_LD;
                    end else begin
                        w_cur_nxt = w_step;
                        w_load    = 1'b1;
                        if (w_step == r_tgt_floor) begin
                            w_state_nxt   = ST_DOOR;
                            w_arrived_nxt = 1'b1;
                            w_load_val    = LP_DOOR_LD;
                        end else begin
                            w_load_val = LP_TRAVEL_LD;
                        end
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_DOOR: begin
                if (w_zero) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign req_ready = (r_state == ST_IDLE);
    assign req_err   = r_req_err;
    assign cur_floor = r_cur_floor;
    assign tgt_floor = r_tgt_floor;
    assign moving    = r_moving;
    assign door_open = r_door_open;
    assign arrived   = r_arrived;

endmodule
